// File: rtl/ldpc_dec_pkg.sv
// Shared types, defaults and width helpers for the QC-LDPC decoder control slice.
package ldpc_dec_pkg;

  localparam int DEF_PCM_COLN     = 72;
  localparam int DEF_PCM_ROWN     = 8;
  localparam int DEF_BLK_SIZE     = 96;
  localparam int DEF_MAX_ITER_LIM = 32;
  localparam int DEF_PIPE_DLY     = 5;

  // Never returns less than 1 so degenerate sizes still yield a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_COL_W  = clog2(DEF_PCM_COLN);
  localparam int DEF_ITER_W = clog2(DEF_MAX_ITER_LIM + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_DRAIN,
    ST_WAIT_SYN,
    ST_OUT
  } sched_state_t;

endpackage

// File: rtl/ldpc_pipe_dly.sv
// WIDTH x DEPTH register shift line with asynchronous active-high clear.
module ldpc_pipe_dly #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/ldpc_sched_ctrl.sv
// Schedule controller for the column-layered QC-LDPC decoder: intake, sweeps, termination, readout.
// Build option: define LDPC_SCHED_EARLY_TERM_EN to let a good syndrome end the ITER phase early.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for first LLR beat (column 0); latches iteration limit
// LOAD     | iteration 0: LLR intake, column advances on accepted beats
// ITER     | free-running sweeps, one column per cycle
// DRAIN    | strobes stopped; waits PIPE_DLY cycles for cn_s pipe to empty
// WAIT_SYN | waits for the syndrome of the final sweep
// OUT      | hard-decision readout with backpressure
module ldpc_sched_ctrl #(
  parameter int PCM_COLN     = ldpc_dec_pkg::DEF_PCM_COLN,
  parameter int MAX_ITER_LIM = ldpc_dec_pkg::DEF_MAX_ITER_LIM,
  parameter int PIPE_DLY     = ldpc_dec_pkg::DEF_PIPE_DLY,
  parameter int COL_W        = ldpc_dec_pkg::clog2(PCM_COLN),
  parameter int ITER_W       = ldpc_dec_pkg::clog2(MAX_ITER_LIM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_llr_we,
  output logic [COL_W-1:0]  o_col_addr,
  output logic              o_first_iter,
  output logic              o_cns_vld,
  output logic [COL_W-1:0]  o_cns_col,
  input  logic              i_syn_vld,
  input  logic              i_syn_ok,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [COL_W-1:0]  o_out_addr,
  output logic              o_out_last,
  output logic              o_done,
  output logic              o_pass,
  output logic [ITER_W-1:0] o_iter_used
);

  import ldpc_dec_pkg::*;

  localparam int DLY_W = clog2(PIPE_DLY + 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(PCM_COLN - 1);
  localparam logic [ITER_W-1:0] LIM_MAX   = ITER_W'(MAX_ITER_LIM);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
  localparam logic [DLY_W-1:0]  DCNT_INIT = DLY_W'(PIPE_DLY - 1);

  sched_state_t      state;
  logic [ITER_W-1:0] iter;
  logic [ITER_W-1:0] lim;
  logic [ITER_W-1:0] lim_in;
  logic [ITER_W-1:0] lim_eff;
  logic [DLY_W-1:0]  dcnt;
  logic              early;
  logic              beat_acc;
  logic              syn_term;
  logic              strobe;
  logic [COL_W:0]    dly_q;

  assign beat_acc = i_in_valid && o_in_ready;
  assign o_llr_we = beat_acc;

`ifdef LDPC_SCHED_EARLY_TERM_EN
  assign syn_term = (state == ST_ITER) && i_syn_vld && i_syn_ok;
`else
  assign syn_term = 1'b0;
`endif

  // o_in_ready is only high in IDLE/LOAD, so beat_acc already covers intake.
  assign strobe = beat_acc || ((state == ST_ITER) && !syn_term);

  always_comb begin
    lim_in = i_max_iter;
    if (i_max_iter == '0)
      lim_in = ITER_ONE;
    else if (i_max_iter > LIM_MAX)
      lim_in = LIM_MAX;
  end

  // A single-column frame finishes intake on the IDLE beat, before lim is registered.
  assign lim_eff = (state == ST_IDLE) ? lim_in : lim;

  ldpc_pipe_dly #(
    .WIDTH (COL_W + 1),
    .DEPTH (PIPE_DLY)
  ) u_cns_dly (
    .clk (clk),
    .rst (rst),
    .d   ({strobe, o_col_addr}),
    .q   (dly_q)
  );

  assign o_cns_vld = dly_q[COL_W];
  assign o_cns_col = dly_q[COL_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      o_in_ready   <= 1'b1;
      o_col_addr   <= '0;
      o_first_iter <= 1'b0;
      iter         <= '0;
      lim          <= '0;
      dcnt         <= '0;
      early        <= 1'b0;
      o_out_valid  <= 1'b0;
      o_out_addr   <= '0;
      o_out_last   <= 1'b0;
      o_done       <= 1'b0;
      o_pass       <= 1'b0;
      o_iter_used  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (beat_acc) begin
            if (state == ST_IDLE) begin
              lim         <= lim_in;
              iter        <= '0;
              early       <= 1'b0;
              o_pass      <= 1'b0;
              o_iter_used <= '0;
            end
            if (o_col_addr == COL_LAST) begin
              o_col_addr   <= '0;
              iter         <= ITER_ONE;
              o_in_ready   <= 1'b0;
              o_first_iter <= 1'b0;
              if (lim_eff > ITER_ONE) begin
                state <= ST_ITER;
              end else begin
                state <= ST_DRAIN;
                dcnt  <= DCNT_INIT;
              end
            end else begin
              o_col_addr   <= o_col_addr + COL_W'(1);
              o_first_iter <= 1'b1;
              state        <= ST_LOAD;
            end
          end
        end

        ST_ITER: begin
          // Termination outranks the wrap so o_iter_used counts only completed sweeps.
          if (syn_term) begin
            o_pass      <= 1'b1;
            o_iter_used <= iter;
            early       <= 1'b1;
            o_col_addr  <= '0;
            state       <= ST_DRAIN;
            dcnt        <= DCNT_INIT;
          end else if (o_col_addr == COL_LAST) begin
            o_col_addr <= '0;
            iter       <= iter + ITER_ONE;
            if (iter == lim - ITER_ONE) begin
              state <= ST_DRAIN;
              dcnt  <= DCNT_INIT;
            end
          end else begin
            o_col_addr <= o_col_addr + COL_W'(1);
          end
        end

        ST_DRAIN: begin
          if (dcnt == '0) begin
            if (early) begin
              state       <= ST_OUT;
              o_done      <= 1'b1;
              o_out_valid <= 1'b1;
              o_out_addr  <= '0;
              o_out_last  <= (COL_LAST == '0);
            end else begin
              state <= ST_WAIT_SYN;
            end
          end else begin
            dcnt <= dcnt - DLY_W'(1);
          end
        end

        ST_WAIT_SYN: begin
          if (i_syn_vld) begin
            o_pass      <= i_syn_ok;
            o_iter_used <= lim;
            state       <= ST_OUT;
            o_done      <= 1'b1;
            o_out_valid <= 1'b1;
            o_out_addr  <= '0;
            o_out_last  <= (COL_LAST == '0);
          end
        end

        ST_OUT: begin
          if (i_out_ready) begin
            if (o_out_last) begin
              state       <= ST_IDLE;
              o_out_valid <= 1'b0;
              o_out_last  <= 1'b0;
              o_out_addr  <= '0;
              o_in_ready  <= 1'b1;
            end else begin
              o_out_addr <= o_out_addr + COL_W'(1);
              o_out_last <= ((o_out_addr + COL_W'(1)) == COL_LAST);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
